// File: rtl/fetch_redirect_if.sv
// IF-stage port bundle: branch-unit redirect, hazard stall, instruction memory and IF/ID outputs.
interface fetch_redirect_if;
  logic        nextPcSrc;
  logic [31:0] aluRes;
  logic        stall;
  logic [31:0] imemInst;
  logic [31:0] imemAddr;
  logic [31:0] pcD;
  logic [31:0] pcInc4D;
  logic [31:0] instD;
  logic        validD;
  logic        flushEx;
  logic        fetchFault;
  logic [31:0] redirectCount;

  modport master (
    output nextPcSrc, aluRes, stall, imemInst,
    input  imemAddr, pcD, pcInc4D, instD, validD, flushEx, fetchFault, redirectCount
  );

  modport slave (
    input  nextPcSrc, aluRes, stall, imemInst,
    output imemAddr, pcD, pcInc4D, instD, validD, flushEx, fetchFault, redirectCount
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// IF stage: owns the PC and IF/ID register, applies redirects/stalls/flushes, traps misaligned targets.
//
// state | meaning
// RUN   | normal fetch, redirects and stalls honoured
// FAULT | misaligned redirect seen; fetch frozen until reset
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_redirect_if.slave bus
);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_d;
  logic [31:0] pc_inc4_d;
  logic [31:0] inst_d;
  logic        valid_d;
  logic        fault;
  logic [31:0] redirect_cnt;
  logic [31:0] pc_inc4;

  assign pc_inc4 = pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      pc           <= RESET_PC;
      pc_d         <= 32'h0;
      pc_inc4_d    <= 32'h0;
      inst_d       <= NOP_INST;
      valid_d      <= 1'b0;
      fault        <= 1'b0;
      redirect_cnt <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (bus.nextPcSrc) begin
            // Redirect beats stall; the wrong-path IF instruction is killed either way.
            inst_d  <= NOP_INST;
            valid_d <= 1'b0;
            if (bus.aluRes[1:0] != 2'b00) begin
              fault <= 1'b1;
              state <= FAULT;
            end else begin
              pc           <= bus.aluRes;
              redirect_cnt <= redirect_cnt + 32'd1;
            end
          end else if (!bus.stall) begin
            pc        <= pc_inc4;
            pc_d      <= pc;
            pc_inc4_d <= pc_inc4;
            inst_d    <= bus.imemInst;
            valid_d   <= 1'b1;
          end
        end
        FAULT: begin
          inst_d  <= NOP_INST;
          valid_d <= 1'b0;
        end
        default: state <= FAULT;
      endcase
    end
  end

  assign bus.imemAddr      = pc;
  assign bus.pcD           = pc_d;
  assign bus.pcInc4D       = pc_inc4_d;
  assign bus.instD         = inst_d;
  assign bus.validD        = valid_d;
  assign bus.fetchFault    = fault;
  assign bus.redirectCount = redirect_cnt;
  assign bus.flushEx       = (state == FAULT) || bus.nextPcSrc;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit with a small combinational instruction memory model.
module tb_fetch_redirect_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fetch_redirect_if ifc ();

  fetch_redirect_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0050_0093;
    if (addr == 32'h4) return 32'h00A0_0113;
    return 32'hA000_0000 | addr;
  endfunction

  assign ifc.imemInst = imem(ifc.imemAddr);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    ifc.nextPcSrc = 1'b0;
    ifc.aluRes    = 32'h0;
    ifc.stall     = 1'b0;
    #12;
    check_val("rst_addr",  ifc.imemAddr, 32'h0);
    check_val("rst_pcD",   ifc.pcD, 32'h0);
    check_val("rst_inc4",  ifc.pcInc4D, 32'h0);
    check_val("rst_inst",  ifc.instD, 32'h13);
    check_val("rst_valid", ifc.validD, 32'h0);
    check_val("rst_fault", ifc.fetchFault, 32'h0);
    check_val("rst_cnt",   ifc.redirectCount, 32'h0);
    check_val("rst_flush", ifc.flushEx, 32'h0);
    rst_n = 1'b1;

    // sequential fetch
    step();
    check_val("seq1_addr",  ifc.imemAddr, 32'h4);
    check_val("seq1_pcD",   ifc.pcD, 32'h0);
    check_val("seq1_inc4",  ifc.pcInc4D, 32'h4);
    check_val("seq1_inst",  ifc.instD, 32'h0050_0093);
    check_val("seq1_valid", ifc.validD, 32'h1);
    step();
    check_val("seq2_addr", ifc.imemAddr, 32'h8);
    check_val("seq2_pcD",  ifc.pcD, 32'h4);
    check_val("seq2_inc4", ifc.pcInc4D, 32'h8);
    check_val("seq2_inst", ifc.instD, 32'h00A0_0113);
    step();
    step();
    check_val("pre_stall_addr", ifc.imemAddr, 32'h10);

    // stall holds PC and IF/ID
    ifc.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall_addr", ifc.imemAddr, 32'h10);
      check_val("stall_pcD",  ifc.pcD, 32'hC);
      check_val("stall_inst", ifc.instD, 32'hA000_000C);
    end
    ifc.stall = 1'b0;
    step();
    check_val("unstall_addr", ifc.imemAddr, 32'h14);
    check_val("unstall_pcD",  ifc.pcD, 32'h10);

    // redirect wins over stall
    ifc.nextPcSrc = 1'b1;
    ifc.aluRes    = 32'h40;
    ifc.stall     = 1'b1;
    #1;
    check_val("rd_flushEx", ifc.flushEx, 32'h1);
    step();
    ifc.nextPcSrc = 1'b0;
    ifc.stall     = 1'b0;
    #1;
    check_val("rd_addr",  ifc.imemAddr, 32'h40);
    check_val("rd_valid", ifc.validD, 32'h0);
    check_val("rd_inst",  ifc.instD, 32'h13);
    check_val("rd_cnt",   ifc.redirectCount, 32'h1);
    check_val("rd_flush_off", ifc.flushEx, 32'h0);

    // fresh reset, then five back-to-back redirects
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst2_addr", ifc.imemAddr, 32'h0);
    check_val("rst2_cnt",  ifc.redirectCount, 32'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      ifc.nextPcSrc = 1'b1;
      ifc.aluRes    = 32'h100 * i;
      step();
      check_val("b2b_valid", ifc.validD, 32'h0);
      check_val("b2b_addr",  ifc.imemAddr, 32'h100 * i);
    end
    check_val("b2b_cnt", ifc.redirectCount, 32'h5);

    // PC wrap
    ifc.aluRes = 32'hFFFF_FFFC;
    step();
    ifc.nextPcSrc = 1'b0;
    check_val("wrap_pre_addr", ifc.imemAddr, 32'hFFFF_FFFC);
    step();
    check_val("wrap_addr",  ifc.imemAddr, 32'h0);
    check_val("wrap_pcD",   ifc.pcD, 32'hFFFF_FFFC);
    check_val("wrap_inc4",  ifc.pcInc4D, 32'h0);
    check_val("wrap_valid", ifc.validD, 32'h1);
    step();
    check_val("wrap_next_addr", ifc.imemAddr, 32'h4);

    // misaligned target traps
    ifc.nextPcSrc = 1'b1;
    ifc.aluRes    = 32'h42;
    step();
    check_val("flt_fault", ifc.fetchFault, 32'h1);
    check_val("flt_addr",  ifc.imemAddr, 32'h4);
    check_val("flt_valid", ifc.validD, 32'h0);
    check_val("flt_cnt",   ifc.redirectCount, 32'h6);
    ifc.aluRes = 32'h80;
    step();
    check_val("flt_ign_addr", ifc.imemAddr, 32'h4);
    check_val("flt_ign_cnt",  ifc.redirectCount, 32'h6);
    ifc.nextPcSrc = 1'b0;
    ifc.stall     = 1'b1;
    #1;
    check_val("flt_flushEx", ifc.flushEx, 32'h1);
    step();
    ifc.stall = 1'b0;
    step();
    check_val("flt_hold_addr",  ifc.imemAddr, 32'h4);
    check_val("flt_hold_valid", ifc.validD, 32'h0);
    check_val("flt_hold_inst",  ifc.instD, 32'h13);
    check_val("flt_hold_flush", ifc.flushEx, 32'h1);

    // asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_fault", ifc.fetchFault, 32'h0);
    check_val("arst_addr",  ifc.imemAddr, 32'h0);
    check_val("arst_flush", ifc.flushEx, 32'h0);
    rst_n = 1'b1;
    step();
    check_val("post_addr", ifc.imemAddr, 32'h4);
    check_val("post_inst", ifc.instD, 32'h0050_0093);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- IF stage of the pipelined RV32I core. Owns the PC and the IF/ID pipeline register, and consumes the taken/not-taken decision (nextPcSrc) and target produced by the EX-stage branch unit.
- Applies PC redirects, stalls from the hazard unit, and IF/ID and ID/EX flushes.
- Traps misaligned redirect targets and counts redirects for performance monitoring.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction injected into IF/ID on flush or reset (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- nextPcSrc  in  1  from EX branch unit; 1 = take redirect to aluRes this cycle.
- aluRes  in  32  EX-stage branch/jump target.
- stall  in  1  hazard unit load-use stall; hold PC and IF/ID.
- imemInst  in  32  instruction memory read data for imemAddr (combinational memory).
- imemAddr  out  32  current fetch address, equal to the PC register.
- pcD  out  32  IF/ID: PC of the instruction in ID.
- pcInc4D  out  32  IF/ID: pcD+4.
- instD  out  32  IF/ID: instruction in ID.
- validD  out  1  IF/ID: 1 = instD is a real fetched instruction.
- flushEx  out  1  combinational; 1 = ID/EX register must load a bubble this cycle.
- fetchFault  out  1  sticky misaligned-target trap flag.
- redirectCount  out  32  number of accepted redirects since reset.

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - pc=RESET_PC, pcD=0, pcInc4D=0, instD=NOP_INST, validD=0
  - fetchFault=0, redirectCount=0, state=RUN.
- imemAddr=pc, combinational. No other output depends combinationally on imemInst.
- States:
  - RUN: normal fetch.
  - FAULT: terminal; left only by reset.
- RUN, per rising edge, first matching row applies:
  1. nextPcSrc=1 and aluRes[1:0]!=0:
     - pc holds; IF/ID loads NOP_INST, validD=0.
     - fetchFault<=1; state<=FAULT; redirectCount unchanged.
  2. nextPcSrc=1, aligned:
     - pc<=aluRes; IF/ID loads NOP_INST/validD=0 (kills wrong-path IF instruction).
     - redirectCount<=redirectCount+1.
  3. stall=1: pc and all IF/ID fields hold.
  4. otherwise:
     - pc<=pc+4 (32-bit wrap: 32'hFFFF_FFFC -> 0).
     - pcD<=pc, pcInc4D<=pc+4, instD<=imemInst, validD<=1.
- flushEx=nextPcSrc in RUN (kills the wrong-path ID instruction). Redirect wins over stall in the same cycle.
- FAULT state:
  - pc holds; IF/ID forced to NOP_INST/validD=0 every cycle; flushEx=1.
  - nextPcSrc and stall are ignored; redirectCount holds.
- redirectCount wraps 32'hFFFF_FFFF -> 0.
- Latency:
  - Redirect: target fetched one cycle after nextPcSrc. Two-instruction branch penalty: one IF/ID NOP plus one ID/EX bubble.
  - Sequential fetch: instruction appears on instD one cycle after imemAddr presents it.
- Reset asserted mid-operation (e.g. during a stall or redirect) overrides everything immediately. First fetch after release is from RESET_PC.

Test Plan:
- Reset release, no stall/redirect, imem holds 0x00500093 at 0 and 0x00A00113 at 4 -> imemAddr 0,4,8,...; cycle 1: pcD=0, instD=0x00500093, validD=1; cycle 2: pcD=4, pcInc4D=8.
- stall=1 for 3 cycles at pc=0x10 -> imemAddr stays 0x10, IF/ID unchanged; after release pc advances to 0x14.
- nextPcSrc=1, aluRes=0x40, stall=1 same cycle -> flushEx=1 that cycle; next cycle imemAddr=0x40, validD=0, instD=0x00000013, redirectCount=1.
- Five back-to-back taken redirects to 0x100,0x200,... -> redirectCount=5, validD stays 0 throughout, last imemAddr equals last target.
- nextPcSrc=1, aluRes=0x42 -> fetchFault=1, imemAddr frozen; later nextPcSrc=1/aluRes=0x80 ignored; flushEx=1 every cycle; assert rst_n=0 -> fetchFault=0, imemAddr=RESET_PC.
- pc preset via redirect to 0xFFFFFFFC, then free run -> next imemAddr=0x00000000, pcD=0xFFFFFFFC, pcInc4D=0x00000000.
